// File: rtl/seq_calc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_calc_unit_if
// Brief    : Operand/request and result/flag bundle between the keypad-side
//            operand entry logic (master) and seq_calc_unit (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface seq_calc_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] mod;
  logic             negative;
  logic             overflow;
  logic             error;

  modport master (
    output start, op, operand1, operand2,
    input  busy, done, result, mod, negative, overflow, error
  );

  modport slave (
    input  start, op, operand1, operand2,
    output busy, done, result, mod, negative, overflow, error
  );
endinterface
`default_nettype wire

// File: rtl/seq_calc_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_calc_unit
// Brief    : Multi-cycle unsigned calculator: single-cycle add/sub, iterative
//            shift-add multiply and restoring divide with start/done handshake.
//            Optional macro CALC_ABORT_EN adds an abort input that cancels a
//            running multiply/divide without a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module seq_calc_unit #(
  parameter int WIDTH    = 32,
  parameter int RES_BITS = 16
) (
  input  logic clk,
  input  logic rst,
`ifdef CALC_ABORT_EN
  input  logic abort,
`endif
  seq_calc_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;       // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opb_q, opb_d;       // multiplicand or divisor
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   mod_q, mod_d;
  logic               negative_q, negative_d;
  logic               overflow_q, overflow_d;
  logic               error_q, error_d;

  logic               abort_req;
  logic [WIDTH:0]     add_sum;
  logic               sub_lt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     div_up;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

`ifdef CALC_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Single-cycle operations work straight off the bus operands.
  assign add_sum = {1'b0, bus.operand1} + {1'b0, bus.operand2};
  assign sub_lt  = bus.operand1 < bus.operand2;

  // One shift-add step; the carry of the upper-half add becomes the new MSB.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring step; the shifted remainder needs WIDTH+1 bits so large
  // divisors compare correctly. After a successful subtract it fits WIDTH bits.
  assign div_sh   = {acc_q, 1'b0};
  assign div_up   = div_sh[2*WIDTH:WIDTH];
  assign div_ge   = div_up >= {1'b0, opb_q};
  assign div_diff = div_up[WIDTH-1:0] - opb_q;
  assign div_next = div_ge ? {div_diff, div_sh[WIDTH-1:1], 1'b1} : div_sh[2*WIDTH-1:0];

  // Next-state, engine and result computation.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    count_d    = count_q;
    result_d   = result_q;
    mod_d      = mod_q;
    negative_d = negative_q;
    overflow_d = overflow_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_ADD: begin
              result_d   = add_sum[WIDTH-1:0];
              mod_d      = '0;
              negative_d = 1'b0;
              overflow_d = |add_sum[WIDTH:RES_BITS];
              error_d    = 1'b0;
              state_d    = S_DONE;
            end
            OP_SUB: begin
              result_d   = sub_lt ? (bus.operand2 - bus.operand1) : (bus.operand1 - bus.operand2);
              mod_d      = '0;
              negative_d = sub_lt;
              overflow_d = 1'b0;
              error_d    = 1'b0;
              state_d    = S_DONE;
            end
            OP_MUL: begin
              acc_d   = {{WIDTH{1'b0}}, bus.operand1};
              opb_d   = bus.operand2;
              count_d = '0;
              state_d = S_MUL;
            end
            default: begin
              if (bus.operand2 == '0) begin
                result_d   = '0;
                mod_d      = '0;
                negative_d = 1'b0;
                overflow_d = 1'b0;
                error_d    = 1'b1;
                state_d    = S_DONE;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, bus.operand1};
                opb_d   = bus.operand2;
                count_d = '0;
                state_d = S_DIV;
              end
            end
          endcase
        end
      end
      S_MUL: begin
        if (abort_req) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = mul_next;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_ITER) begin
            result_d   = mul_next[WIDTH-1:0];
            mod_d      = '0;
            negative_d = 1'b0;
            overflow_d = |mul_next[2*WIDTH-1:RES_BITS];
            error_d    = 1'b0;
            state_d    = S_DONE;
          end
        end
      end
      S_DIV: begin
        if (abort_req) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = div_next;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_ITER) begin
            result_d   = div_next[WIDTH-1:0];
            mod_d      = div_next[2*WIDTH-1:WIDTH];
            negative_d = 1'b0;
            overflow_d = 1'b0;
            error_d    = 1'b0;
            state_d    = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, engine and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      opb_q      <= '0;
      count_q    <= '0;
      result_q   <= '0;
      mod_q      <= '0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      count_q    <= count_d;
      result_q   <= result_d;
      mod_q      <= mod_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

  assign bus.busy     = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.mod      = mod_q;
  assign bus.negative = negative_q;
  assign bus.overflow = overflow_q;
  assign bus.error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_calc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_calc_unit
// Brief    : Scoreboard bench for seq_calc_unit (WIDTH=32, RES_BITS=16).
//            Honours CALC_ABORT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_calc_unit;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [31:0] md;
    logic        neg;
    logic        ovf;
    logic        err;
    int          lat;
    int          scyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef CALC_ABORT_EN
  logic abort = 1'b0;
`endif
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   next_id = 0;
  exp_t sb[$];

  seq_calc_unit_if #(.WIDTH(32)) bus ();

  seq_calc_unit #(.WIDTH(32), .RES_BITS(16)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef CALC_ABORT_EN
    .abort(abort),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (op #%0d): got 0x%0h, expected 0x%0h", name, id, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done at cycle %0d: got done=1, expected 0", cyc);
        end else begin
          e = sb.pop_front();
          chk("result",   e.id, 64'(bus.result),   64'(e.res));
          chk("mod",      e.id, 64'(bus.mod),      64'(e.md));
          chk("negative", e.id, 64'(bus.negative), 64'(e.neg));
          chk("overflow", e.id, 64'(bus.overflow), 64'(e.ovf));
          chk("error",    e.id, 64'(bus.error),    64'(e.err));
          chk("latency",  e.id, 64'(cyc - e.scyc), 64'(e.lat));
        end
      end
    end
  end

  // Drive one request for a single cycle, then scramble the operands.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [31:0] em,
                       input logic en, input logic eo, input logic ee, input int lat);
    exp_t e;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.operand1 = a;
    bus.operand2 = b;
    e.id = next_id; e.res = er; e.md = em; e.neg = en; e.ovf = eo; e.err = ee;
    e.lat = lat; e.scyc = cyc;
    next_id++;
    sb.push_back(e);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.op       = ~op;
    bus.operand1 = ~a;
    bus.operand2 = ~b;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL timeout: %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.operand1 = '0; bus.operand2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", -1, 64'(bus.result), 64'd0);
    chk("reset_busy",   -1, 64'(bus.busy),   64'd0);
    chk("reset_done",   -1, 64'(bus.done),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    // add / sub
    issue(2'b00, 32'h0000FFFF, 32'h1, 32'h00010000, 32'h0, 1'b0, 1'b1, 1'b0, 1);  wait_drain();
    issue(2'b00, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'h0, 1'b0, 1'b1, 1'b0, 1);  wait_drain();
    issue(2'b01, 32'd5, 32'd9, 32'd4, 32'h0, 1'b1, 1'b0, 1'b0, 1);                wait_drain();
    issue(2'b01, 32'd9, 32'd9, 32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1);                wait_drain();

    // mul
    issue(2'b10, 32'd255, 32'd255, 32'd65025, 32'h0, 1'b0, 1'b0, 1'b0, 33);       wait_drain();
    issue(2'b10, 32'd300, 32'd300, 32'd90000, 32'h0, 1'b0, 1'b1, 1'b0, 33);       wait_drain();
    repeat (4) @(negedge clk);
    chk("hold_result", -1, 64'(bus.result),   64'd90000);
    chk("hold_ovf",    -1, 64'(bus.overflow), 64'd1);

    // div, with an ignored start pulse around cycle 10
    issue(2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 33);
    chk("busy_in_div", -1, 64'(bus.busy), 64'd1);
    repeat (8) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.operand1 = 32'd1; bus.operand2 = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (5) @(negedge clk);
    issue(2'b11, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1);                          wait_drain();
    issue(2'b11, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0, 33);          wait_drain();
    issue(2'b11, 32'hFFFFFFFF, 32'h80000001, 32'd1, 32'h7FFFFFFE, 1'b0, 1'b0, 1'b0, 33);   wait_drain();

    // reset in the middle of a mul
    issue(2'b10, 32'd300, 32'd300, 32'd90000, 32'h0, 1'b0, 1'b1, 1'b0, 33);
    repeat (18) @(negedge clk);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_result",   -1, 64'(bus.result),   64'd0);
    chk("rst_mod",      -1, 64'(bus.mod),      64'd0);
    chk("rst_negative", -1, 64'(bus.negative), 64'd0);
    chk("rst_overflow", -1, 64'(bus.overflow), 64'd0);
    chk("rst_error",    -1, 64'(bus.error),    64'd0);
    chk("rst_busy",     -1, 64'(bus.busy),     64'd0);
    chk("rst_done",     -1, 64'(bus.done),     64'd0);
    repeat (40) @(negedge clk);

`ifdef CALC_ABORT_EN
    issue(2'b00, 32'd1, 32'd2, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1);  wait_drain();
    issue(2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 33);
    repeat (3) @(negedge clk);
    sb.delete();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy",   -1, 64'(bus.busy),   64'd0);
    chk("abort_done",   -1, 64'(bus.done),   64'd0);
    chk("abort_result", -1, 64'(bus.result), 64'd3);
    repeat (40) @(negedge clk);
    chk("abort_hold",   -1, 64'(bus.result), 64'd3);
    issue(2'b00, 32'd2, 32'd2, 32'd4, 32'h0, 1'b0, 1'b0, 1'b0, 1);  wait_drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
